// File: rtl/dma_pkg.sv
// ============================================================================
//  Module : dma_pkg
//  Brief  : Shared DMA descriptor, status and scheduler types.
//  Rev    : 1.0  initial multi-channel scheduler types
// ============================================================================
`default_nettype none

`ifndef DMA_NUM_CH
`define DMA_NUM_CH 4
`endif
`ifndef DMA_CHUNK_BYTES
`define DMA_CHUNK_BYTES 4096
`endif

package dma_pkg;

  localparam int DMA_BYTES_WIDTH = 32;
  localparam int DMA_NUM_CH      = `DMA_NUM_CH;
  localparam int DMA_CHUNK_BYTES = `DMA_CHUNK_BYTES;
  localparam int DMA_CH_W        = $clog2(DMA_NUM_CH);

  typedef struct packed {
    logic [31:0]                src;
    logic [31:0]                dst;
    logic [DMA_BYTES_WIDTH-1:0] num_bytes;
  } s_dma_desc_t;

  typedef struct packed {
    logic error;
    logic done;
    logic active;
  } s_dma_status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } dma_sched_st_t;

  typedef struct packed {
    s_dma_desc_t         desc;
    logic [DMA_CH_W-1:0] ch;
    logic                valid;
  } s_dma_chunk_req_t;

endpackage

`default_nettype wire

// File: rtl/dma_desc_fifo.sv
// ============================================================================
//  Module : dma_desc_fifo
//  Brief  : Per-channel descriptor queue with flush and in-place head update.
//  Rev    : 1.0  initial
// ============================================================================
`default_nettype none

module dma_desc_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 96,
  localparam int AW     = $clog2(DEPTH),
  localparam int CNT_W  = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic              wr_head_i,
  input  logic [DATA_W-1:0] wr_head_data_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  // A full queue refuses a push even if the head leaves in the same cycle.
  assign push_ok = push_i & ~full_o;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = wr_q;
      cnt_d = '0;
    end else if (pop_i && !empty_o) begin
      rd_d  = rd_q + 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
    if (push_ok) begin
      wr_d  = wr_q + 1'b1;
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= push_data_i;
    end
    if (wr_head_i && !flush_i) begin
      mem_q[rd_q] <= wr_head_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dma_chan_sched.sv
// ============================================================================
//  Module : dma_chan_sched
//  Brief  : Round-robin multi-channel descriptor scheduler with chunk splitting.
//  Rev    : 1.0  initial
// ============================================================================
`default_nettype none

module dma_chan_sched
  import dma_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int DESC_DEPTH  = 4,
  parameter  int CHUNK_BYTES = 4096,
  parameter  int BYTES_W     = 32,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    push_valid,
  output logic [NUM_CH-1:0]    push_ready,
  input  logic [NUM_CH*96-1:0] push_desc,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic [95:0]          req_desc,
  output logic [CH_W-1:0]      req_ch,
  input  logic                 cpl_valid,
  input  logic                 cpl_error,
  input  logic [NUM_CH-1:0]    abort,
  input  logic [NUM_CH-1:0]    clr_status,
  output logic [NUM_CH*3-1:0]  ch_status
);

  localparam int CNT_W = $clog2(DESC_DEPTH) + 1;

  dma_sched_st_t     state_q, state_d;
  logic [CH_W-1:0]   rr_q, rr_d, gnt_q, gnt_d, gnt_sel, rr_nxt, idx;
  logic [CH_W:0]     sum;
  s_dma_desc_t       req_q, req_d;
  logic [NUM_CH-1:0] done_q, done_d, err_q, err_d, pend_q, pend_d;
  logic [NUM_CH-1:0] done_set, err_set;
  logic [NUM_CH-1:0] full, empty, push_fire, pop, flush, wr_head, cand, inflight;
  s_dma_desc_t       head [NUM_CH];
  logic [CNT_W-1:0]  count [NUM_CH];
  s_dma_desc_t       sel_head, gnt_head, wr_data;
  logic [BYTES_W-1:0] chunk_sel;
  logic              found, abort_now, any_work;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      assign push_ready[g] = ~full[g] & ~err_q[g];
      assign push_fire[g]  = push_valid[g] & push_ready[g];
      assign inflight[g]   = ((state_q == ISSUE) || (state_q == WAIT)) && (gnt_q == CH_W'(g));
      assign ch_status[g*3 +: 3] = {err_q[g], done_q[g], ~empty[g] | inflight[g]};

      dma_desc_fifo #(
        .DEPTH  (DESC_DEPTH),
        .DATA_W ($bits(s_dma_desc_t))
      ) u_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .push_i         (push_fire[g]),
        .push_data_i    (push_desc[g*96 +: 96]),
        .pop_i          (pop[g]),
        .flush_i        (flush[g]),
        .wr_head_i      (wr_head[g]),
        .wr_head_data_i (wr_data),
        .head_o         (head[g]),
        .full_o         (full[g]),
        .empty_o        (empty[g]),
        .count_o        (count[g])
      );
    end
  endgenerate

  // A channel being aborted this cycle is not granted, so its flush cannot race an issue.
  assign cand      = ~empty & ~abort;
  assign any_work  = (|(~empty)) | (|push_fire);
  assign sel_head  = head[gnt_sel];
  assign gnt_head  = head[gnt_q];
  assign chunk_sel = (sel_head.num_bytes > BYTES_W'(CHUNK_BYTES)) ? BYTES_W'(CHUNK_BYTES)
                                                                  : sel_head.num_bytes;
  assign wr_data   = {gnt_head.src + req_q.num_bytes,
                      gnt_head.dst + req_q.num_bytes,
                      gnt_head.num_bytes - req_q.num_bytes};
  assign rr_nxt    = (gnt_q == CH_W'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;
  assign abort_now = pend_q[gnt_q] | abort[gnt_q];

  assign req_valid = (state_q == ISSUE);
  assign req_desc  = req_q;
  assign req_ch    = gnt_q;

  always_comb begin
    found   = 1'b0;
    gnt_sel = '0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, rr_q} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      idx = sum[CH_W-1:0];
      if (!found && cand[idx]) begin
        found   = 1'b1;
        gnt_sel = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    req_d    = req_q;
    pend_d   = pend_q;
    pop      = '0;
    flush    = '0;
    wr_head  = '0;
    done_set = '0;
    err_set  = '0;

    for (int i = 0; i < NUM_CH; i++) begin
      if (abort[i] && !empty[i]) begin
        if (inflight[i]) pend_d[i] = 1'b1;
        else             flush[i]  = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (any_work) state_d = ARB;
      end
      ARB: begin
        if (!found) begin
          state_d = IDLE;
        end else if (sel_head.num_bytes == '0) begin
          pop[gnt_sel] = 1'b1;
          if (count[gnt_sel] == CNT_W'(1) && !push_fire[gnt_sel]) done_set[gnt_sel] = 1'b1;
        end else begin
          req_d   = {sel_head.src, sel_head.dst, chunk_sel};
          gnt_d   = gnt_sel;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (cpl_valid) begin
          rr_d          = rr_nxt;
          state_d       = any_work ? ARB : IDLE;
          pend_d[gnt_q] = 1'b0;
          if (cpl_error || abort_now) begin
            flush[gnt_q]   = 1'b1;
            err_set[gnt_q] = cpl_error;
          end else if (gnt_head.num_bytes == req_q.num_bytes) begin
            pop[gnt_q] = 1'b1;
            if (count[gnt_q] == CNT_W'(1) && !push_fire[gnt_q]) done_set[gnt_q] = 1'b1;
          end else begin
            wr_head[gnt_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    done_d = (done_q & ~clr_status) | done_set;
    err_d  = (err_q & ~clr_status) | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      req_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_chan_sched.sv
// ============================================================================
//  Module : tb_dma_chan_sched
//  Brief  : Scoreboard bench for the round-robin chunk scheduler.
//  Rev    : 1.0  initial
// ============================================================================
`default_nettype none

module tb_dma_chan_sched;

  typedef logic [95:0] chunk_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   push_valid, push_ready, abort, clr_status;
  logic [383:0] push_desc;
  logic         req_valid, req_ready, cpl_valid, cpl_error;
  logic [95:0]  req_desc;
  logic [1:0]   req_ch;
  logic [11:0]  ch_status;

  chunk_t exp_q [4][$];
  int checks = 0;
  int errors = 0;

  dma_chan_sched #(
    .NUM_CH(4), .DESC_DEPTH(4), .CHUNK_BYTES(4096), .BYTES_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(push_ready), .push_desc(push_desc),
    .req_valid(req_valid), .req_ready(req_ready), .req_desc(req_desc), .req_ch(req_ch),
    .cpl_valid(cpl_valid), .cpl_error(cpl_error),
    .abort(abort), .clr_status(clr_status), .ch_status(ch_status)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired: errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Expected chunk sequence of one descriptor, split at 4096 bytes.
  task automatic gen_exp(input int ch, input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    logic [31:0] c;
    while (n != 0) begin
      c = (n > 32'd4096) ? 32'd4096 : n;
      exp_q[ch].push_back({s, d, c});
      s = s + c;
      d = d + c;
      n = n - c;
    end
  endtask

  task automatic do_push(input int ch, input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    int t = 0;
    @(negedge clk);
    while (!push_ready[ch] && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!push_ready[ch]) begin
      errors++;
      $display("FAIL push_ready_ch%0d got 0 want 1", ch);
    end
    push_desc[ch*96 +: 96] = {s, d, n};
    push_valid[ch] = 1'b1;
    gen_exp(ch, s, d, n);
    @(negedge clk);
    push_valid[ch] = 1'b0;
  endtask

  task automatic xfer(input bit err, output chunk_t d, output logic [1:0] c, output bit ok);
    ok = 1'b0;
    d  = '0;
    c  = '0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (req_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      d = req_desc;
      c = req_ch;
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      cpl_valid = 1'b1;
      cpl_error = err;
      @(negedge clk);
      cpl_valid = 1'b0;
      cpl_error = 1'b0;
    end
  endtask

  task automatic pulse_clr(input logic [3:0] m);
    @(negedge clk);
    clr_status = m;
    @(negedge clk);
    clr_status = '0;
  endtask

  task automatic test_reset;
    checks++;
    if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", req_valid); end
    checks++;
    if (req_desc !== 96'd0) begin errors++; $display("FAIL reset_req_desc got %h want 0", req_desc); end
    checks++;
    if (req_ch !== 2'd0) begin errors++; $display("FAIL reset_req_ch got %0d want 0", req_ch); end
    checks++;
    if (ch_status !== 12'd0) begin errors++; $display("FAIL reset_status got %h want 0", ch_status); end
    checks++;
    if (push_ready !== 4'hF) begin errors++; $display("FAIL reset_push_ready got %b want 1111", push_ready); end
  endtask

  task automatic test_round_robin;
    chunk_t d, e;
    logic [1:0] c;
    bit ok;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      push_desc[k*96 +: 96] = {32'h0001_0000 * (k + 1), 32'h0010_0000 * (k + 1), 32'h2000};
      gen_exp(k, 32'h0001_0000 * (k + 1), 32'h0010_0000 * (k + 1), 32'h2000);
    end
    push_valid = 4'hF;
    @(negedge clk);
    push_valid = 4'h0;
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, d, c, ok);
      e = '0;
      if (exp_q[i % 4].size() > 0) e = exp_q[i % 4].pop_front();
      checks++;
      if (!ok || c !== 2'(i % 4) || d !== e) begin
        errors++;
        $display("FAIL rr_chunk%0d got ok=%0d ch=%0d desc=%h want ch=%0d desc=%h", i, ok, c, d, i % 4, e);
      end
    end
    @(negedge clk);
    checks++;
    if (ch_status !== {4{3'b010}}) begin errors++; $display("FAIL rr_status got %h want %h", ch_status, {4{3'b010}}); end
  endtask

  task automatic test_single;
    chunk_t d, e;
    logic [1:0] c;
    bit ok;
    pulse_clr(4'hF);
    do_push(0, 32'h1000, 32'h8000, 32'h2800);
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, d, c, ok);
      e = '0;
      if (exp_q[0].size() > 0) e = exp_q[0].pop_front();
      checks++;
      if (!ok || c !== 2'd0 || d !== e) begin
        errors++;
        $display("FAIL single_chunk%0d got ok=%0d ch=%0d desc=%h want ch=0 desc=%h", i, ok, c, d, e);
      end
    end
    @(negedge clk);
    checks++;
    if (ch_status[2:0] !== 3'b010) begin errors++; $display("FAIL single_status got %b want 010", ch_status[2:0]); end
  endtask

  task automatic test_error;
    chunk_t d, e;
    logic [1:0] c;
    bit ok;
    pulse_clr(4'hF);
    do_push(1, 32'h2000_0000, 32'h3000_0000, 32'h1800);
    do_push(1, 32'h2100_0000, 32'h3100_0000, 32'h1000);
    xfer(1'b1, d, c, ok);
    e = '0;
    if (exp_q[1].size() > 0) e = exp_q[1].pop_front();
    exp_q[1].delete();
    checks++;
    if (!ok || c !== 2'd1 || d !== e) begin
      errors++;
      $display("FAIL err_chunk got ok=%0d ch=%0d desc=%h want ch=1 desc=%h", ok, c, d, e);
    end
    checks++;
    if (ch_status[5:3] !== 3'b100) begin errors++; $display("FAIL err_status got %b want 100", ch_status[5:3]); end
    checks++;
    if (push_ready[1] !== 1'b0) begin errors++; $display("FAIL err_push_ready got %b want 0", push_ready[1]); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_valid !== 1'b0) begin errors++; $display("FAIL err_flushed cycle%0d req_valid got %b want 0", i, req_valid); end
    end
    pulse_clr(4'b0010);
    checks++;
    if (push_ready[1] !== 1'b1) begin errors++; $display("FAIL clr_push_ready got %b want 1", push_ready[1]); end
    checks++;
    if (ch_status[5:3] !== 3'b000) begin errors++; $display("FAIL clr_status got %b want 000", ch_status[5:3]); end
  endtask

  task automatic test_zero_and_depth;
    chunk_t d, e;
    logic [1:0] c;
    bit ok;
    int acc = 0;
    pulse_clr(4'hF);
    checks++;
    if (ch_status !== 12'd0) begin errors++; $display("FAIL clr_all got %h want 0", ch_status); end
    @(negedge clk);
    push_desc[2*96 +: 96] = {32'h1234_0000, 32'h5678_0000, 32'h0};
    push_valid[2] = 1'b1;
    @(negedge clk);
    push_valid[2] = 1'b0;
    checks++;
    if (req_valid !== 1'b0) begin errors++; $display("FAIL zero_req_t1 got %b want 0", req_valid); end
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b0 || ch_status[8:6] !== 3'b010) begin
      errors++;
      $display("FAIL zero_done got req_valid=%b status=%b want 0 010", req_valid, ch_status[8:6]);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      push_desc[3*96 +: 96] = {32'h4000_0000 + 32'(i) * 32'h100, 32'h5000_0000 + 32'(i) * 32'h100, 32'h1000};
      push_valid[3] = 1'b1;
      if (push_ready[3]) begin
        acc++;
        gen_exp(3, 32'h4000_0000 + 32'(i) * 32'h100, 32'h5000_0000 + 32'(i) * 32'h100, 32'h1000);
      end
    end
    checks++;
    if (push_ready[3] !== 1'b0) begin errors++; $display("FAIL depth_full got push_ready=%b want 0", push_ready[3]); end
    @(negedge clk);
    push_valid[3] = 1'b0;
    checks++;
    if (acc != 4) begin errors++; $display("FAIL depth_accept got %0d want 4", acc); end
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, d, c, ok);
      e = '0;
      if (exp_q[3].size() > 0) e = exp_q[3].pop_front();
      checks++;
      if (!ok || c !== 2'd3 || d !== e) begin
        errors++;
        $display("FAIL depth_chunk%0d got ok=%0d ch=%0d desc=%h want ch=3 desc=%h", i, ok, c, d, e);
      end
    end
    @(negedge clk);
    checks++;
    if (ch_status[11:9] !== 3'b010) begin errors++; $display("FAIL depth_status got %b want 010", ch_status[11:9]); end
  endtask

  task automatic test_abort;
    chunk_t d0, e;
    bit ok = 1'b0;
    pulse_clr(4'hF);
    do_push(0, 32'h6000_0000, 32'h7000_0000, 32'h2000);
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = req_valid;
    end
    d0 = req_desc;
    e  = '0;
    if (exp_q[0].size() > 0) e = exp_q[0].pop_front();
    exp_q[0].delete();
    checks++;
    if (!ok || d0 !== e) begin errors++; $display("FAIL abort_chunk got ok=%0d desc=%h want %h", ok, d0, e); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_valid !== 1'b1 || req_desc !== e) begin
        errors++;
        $display("FAIL hold_stable cycle%0d got valid=%b desc=%h want 1 %h", i, req_valid, req_desc, e);
      end
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    abort[0]  = 1'b1;
    @(negedge clk);
    abort[0]  = 1'b0;
    cpl_valid = 1'b1;
    @(negedge clk);
    cpl_valid = 1'b0;
    checks++;
    if (ch_status[2:0] !== 3'b000) begin errors++; $display("FAIL abort_status got %b want 000", ch_status[2:0]); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_valid !== 1'b0) begin errors++; $display("FAIL abort_flushed cycle%0d req_valid got %b want 0", i, req_valid); end
    end
  endtask

  task automatic test_reset_mid;
    bit ok = 1'b0;
    do_push(1, 32'h8000_0000, 32'h9000_0000, 32'h1000);
    exp_q[1].delete();
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = req_valid;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_issue got req_valid=0 want 1"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_valid !== 1'b0) begin errors++; $display("FAIL mid_async_req got %b want 0", req_valid); end
    checks++;
    if (ch_status !== 12'd0 || push_ready !== 4'hF) begin
      errors++;
      $display("FAIL mid_async_state got status=%h ready=%b want 0 1111", ch_status, push_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cpl_valid = 1'b1;
    @(negedge clk);
    cpl_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ch_status !== 12'd0 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_cpl got status=%h req_valid=%b want 0 0", ch_status, req_valid);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    push_valid = '0;
    push_desc  = '0;
    req_ready  = 1'b0;
    cpl_valid  = 1'b0;
    cpl_error  = 1'b0;
    abort      = '0;
    clr_status = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_round_robin();
    test_single();
    test_error();
    test_zero_and_depth();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
